mem_responder: RTL



---
 rtl/mem_responder.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Memory-side responder for the core's load/store path. It accepts one
// request at a time, waits a fixed number of cycles, and then returns a
// response on a valid/ready channel. Storage is an internal array of 32-bit
// words. Byte address BASE maps to word 0.
//
// Parameters:
//   ADDR_W      request address width
//   DEPTH_LOG2  log2 of storage depth in 32-bit words
//   BASE        byte address mapped to word 0
//   LATENCY     wait cycles between request accept and response valid (0..15)
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous, active-high reset
//   req_valid  request present
//   req_ready  responder can accept a request (IDLE only, 0 during reset)
//   req_wen    1 = store, 0 = load
//   req_addr   byte address; bits [1:0] are ignored
//   req_wdata  store data
//   req_wmask  store byte enables; bit i enables byte i
//   rsp_valid  response present
//   rsp_ready  requester accepts the response
//   rsp_rdata  load data; 0 for stores and errors
//   rsp_err    address outside [BASE, BASE + 4*2^DEPTH_LOG2)
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int unsigned        ADDR_W     = 32,
    parameter int unsigned        DEPTH_LOG2 = 10,
    parameter logic [ADDR_W-1:0]  BASE       = ADDR_W'(32'h8000_0000),
    parameter int unsigned        LATENCY    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_wmask,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned       DEPTH = 1 << DEPTH_LOG2;
    // Size of the mapped window in bytes.
    localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(DEPTH * 4);
    localparam logic [3:0]        LAT4  = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                  state;
    logic [3:0]              cnt;

    // Request fields captured at accept, used when the commit happens later.
    logic                    wen_q;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic [31:0]             wdata_q;
    logic [3:0]              wmask_q;
    logic                    inrange_q;

    logic [31:0]             mem [DEPTH];

    logic [ADDR_W-1:0]       off;
    logic                    req_inrange;
    logic                    accept;

    // Commit view: what gets written or read on the edge that enters RESP.
    logic                    go_resp;
    logic                    c_wen;
    logic [DEPTH_LOG2-1:0]   c_idx;
    logic [31:0]             c_wdata;
    logic [3:0]              c_wmask;
    logic                    c_inrange;
    logic [31:0]             c_rdata;

    // Subtraction wraps modulo 2^ADDR_W, so addresses below BASE turn into
    // very large offsets. The explicit >= BASE test rejects them anyway.
    assign off         = req_addr - BASE;
    assign req_inrange = (req_addr >= BASE) && (off < SPAN);

    assign req_ready   = (state == IDLE) && !rst;
    assign accept      = req_valid && req_ready;

    // With LATENCY == 0 the commit happens on the accept edge itself. It must
    // use the live request. Otherwise it uses the fields captured at accept.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // through the case statement can leave it unassigned and infer a latch.
        go_resp   = 1'b0;
        c_wen     = wen_q;
        c_idx     = idx_q;
        c_wdata   = wdata_q;
        c_wmask   = wmask_q;
        c_inrange = inrange_q;
        case (state)
            IDLE: begin
                c_wen     = req_wen;
                c_idx     = off[DEPTH_LOG2+1:2];
                c_wdata   = req_wdata;
                c_wmask   = req_wmask;
                c_inrange = req_inrange;
                go_resp   = accept && (LATENCY == 0);
            end
            WAIT:    go_resp = (cnt == 4'd1);
            default: go_resp = 1'b0;
        endcase
        c_rdata = (c_inrange && !c_wen) ? mem[c_idx] : 32'h0;
    end

    // Storage write port. Only enabled bytes of an in-range store change.
    // A reset in WAIT moves the state to IDLE before the commit edge, so the
    // pending store is dropped.
    // NOTE: the storage array has no reset. Its contents survive rst, and a
    // reset branch would prevent mapping the array onto RAM.
    always_ff @(posedge clk) begin
        if (go_resp && c_wen && c_inrange) begin
            for (int b = 0; b < 4; b++) begin
                if (c_wmask[b]) begin
                    mem[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
                end
            end
        end
    end

    // Control FSM with registered response outputs.
    // NOTE: sequential state is updated only with non-blocking assignments.
    // All registers then see pre-edge values, and the last assignment wins,
    // as the go_resp override below relies on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            wen_q     <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= 32'h0;
            wmask_q   <= 4'h0;
            inrange_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        wen_q     <= req_wen;
                        idx_q     <= off[DEPTH_LOG2+1:2];
                        wdata_q   <= req_wdata;
                        wmask_q   <= req_wmask;
                        inrange_q <= req_inrange;
                        if (LATENCY != 0) begin
                            cnt   <= LAT4;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                end
                RESP: begin
                    // Outputs hold until the handshake. req_ready reappears
                    // only after the state register returns to IDLE.
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 32'h0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            // The commit edge: present the response and enter RESP.
            if (go_resp) begin
                state     <= RESP;
                rsp_valid <= 1'b1;
                rsp_err   <= !c_inrange;
                rsp_rdata <= c_rdata;
            end
        end
    end

endmodule
